commit_trace_fifo: RTL
======================

// Module: commit_trace_fifo
// PURPOSE
//  Parametrised commit-trace capture buffer for the simulation/debug harness. Snoops the core's
//  N-lane commit bus each cycle, packs valid lanes in program order into a FIFO, and drains one
//  entry per cycle to a trace sink over valid/ready. Never back-pressures the core: whole-cycle
//  groups that do not fit are dropped and counted.
// PARAMETERS
//  NUM_LANES  2   commit lanes (1..4); lane 0 is oldest in program order
//  DEPTH      16  FIFO entries; power of two, >= NUM_LANES
//  CNT_W      16  width of the saturating drop counter
//  TS_W       32  timestamp width (used only with COMMIT_TRACE_TIMESTAMP_EN)
//  Derived: LANE_W = max(1,clog2(NUM_LANES)); ENTRY_W = LANE_W+70; OUT_W = ENTRY_W (+TS_W with macro)
// PORTS
//  clk          in   1              clock
//  rst_n        in   1              asynchronous active-low reset
//  commit       in   NUM_LANES*71   per lane {pc_valid,pc[31:0],wp_valid,wp_i[4:0],wp_v[31:0]}, lane 0 in MSBs
//  trace_valid  out  1              head entry available
//  trace_ready  in   1              sink accepts head entry
//  trace_data   out  OUT_W          {lane,pc,wp_valid,wp_i,wp_v[,ts]}
//  level        out  clog2(DEPTH)+1 current occupancy
//  overflow     out  1              sticky: at least one group dropped since reset
//  drop_count   out  CNT_W          dropped commit groups, saturates at all-ones
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFO empty, trace_valid=0, trace_data=0, level=0,
//    overflow=0, drop_count=0, timestamp=0. Reset mid-drain discards all contents.
//  - Capture: k = popcount of pc_valid bits. If k==0: nothing. If k <= DEPTH-level (level at
//    start of cycle; a same-cycle pop does not free space): write k entries at wr_ptr..wr_ptr+k-1,
//    ascending lane order, skipping invalid lanes; wr_ptr += k mod DEPTH (wraps).
//  - Overflow: if k > free, drop ALL k lanes of that cycle (atomic group), overflow<=1,
//    drop_count += 1 unless saturated. Partial groups never written.
//  - wp_* fields stored verbatim even when wp_valid=0; entries with pc_valid=0 never stored.
//  - Latency: entry captured at edge N is presented (trace_valid=1) after edge N when FIFO was empty.
//  - Drain: pop when trace_valid && trace_ready; one entry per cycle max. While trace_valid &&
//    !trace_ready, trace_data held stable. trace_data = 0 when empty.
//  - Simultaneous push k and pop: level <= level + k - 1 in same edge.
//  - Full (level==DEPTH): trace_valid=1, any k>0 drops. Empty: trace_ready ignored.
//  - Pointers are clog2(DEPTH)+1 bits; full/empty from MSB compare; level = wr_ptr - rd_ptr.
// CONFIGURATION
//  COMMIT_TRACE_TIMESTAMP_EN defined: free-running TS_W-bit cycle counter, 0 after reset,
//    +1 every cycle, wraps to 0; all lanes captured in a cycle carry that cycle's counter value
//    in the trace_data LSBs; OUT_W = ENTRY_W+TS_W.
//  Not defined: no counter, OUT_W = ENTRY_W, entry format otherwise identical.
// TESTING
//  1 Reset, NUM_LANES=2, ready=1; lane0 {pc=0x100,wp 3=0xAA}, lane1 invalid -> next cycle
//    trace_valid=1, data lane=0 pc=0x100 wp_i=3 wp_v=0xAA; following cycle trace_valid=0.
//  2 Both lanes valid pc=0x200/0x204, ready=1 -> two consecutive entries lane0 then lane1, order kept.
//  3 ready=0, 8 cycles dual commit, DEPTH=16 -> level=16, overflow=0; 9th dual commit ->
//    level stays 16, drop_count=1, overflow=1; set ready=1 -> 16 entries drain in order.
//  4 level=15, ready=1, dual commit -> group dropped (k=2 > free 1 at cycle start), drop_count+1,
//    level=14 after edge.
//  5 ready toggled 1/0 every cycle with continuous single commits over 3*DEPTH cycles -> no loss,
//    trace_data stable while stalled, pointers wrap correctly.
//  6 With COMMIT_TRACE_TIMESTAMP_EN: dual commit at cycle 5 after reset -> both entries ts=5;
//    assert rst_n mid-drain -> trace_valid=0, level=0, ts=0 immediately.

Source files
------------

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo
//   Commit-trace capture buffer. Snoops an N-lane commit bus every cycle,
//   packs the valid lanes (oldest lane first) into a FIFO and drains one
//   entry per cycle to a trace sink over valid/ready. The core is never
//   back-pressured. A cycle's group of valid lanes is written whole or not
//   at all. Dropped groups set a sticky flag and bump a saturating counter.
//
//   Optional feature macro: COMMIT_TRACE_TIMESTAMP_EN
//     When defined, a free-running TS_W-bit cycle counter is appended to
//     every entry (LSBs).
//
// Ports
//   clk          clock
//   rst_n        async active-low reset
//   commit       NUM_LANES x {pc_valid,pc[31:0],wp_valid,wp_i[4:0],wp_v[31:0]}, lane 0 in MSBs
//   trace_valid  head entry available
//   trace_ready  sink accepts head entry
//   trace_data   {lane,pc,wp_valid,wp_i,wp_v[,ts]}, zero when empty
//   level        current occupancy
//   overflow     sticky, a group was dropped since reset
//   drop_count   dropped groups, saturating

// Per-lane unpack: valid flag plus the entry body tagged with the lane index.
module commit_trace_lane #(
  parameter int LANE_W   = 1,
  parameter int LANE_IDX = 0
) (
  input  logic [70:0]        lane_bus,
  output logic               vld,
  output logic [LANE_W+69:0] entry
);
  assign vld   = lane_bus[70];
  assign entry = {LANE_W'(LANE_IDX), lane_bus[69:0]};
endmodule

module commit_trace_fifo #(
  parameter int NUM_LANES = 2,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 16,
  parameter int TS_W      = 32,
  localparam int AW       = $clog2(DEPTH),
  localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  localparam int ENTRY_W  = LANE_W + 70,
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  localparam bit TS_EN    = 1'b1,
`else
  localparam bit TS_EN    = 1'b0,
`endif
  localparam int OUT_W    = ENTRY_W + (TS_EN ? TS_W : 0)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_LANES*71-1:0] commit,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [OUT_W-1:0]       trace_data,
  output logic [AW:0]            level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count
);

  logic [NUM_LANES-1:0]              lane_vld;
  logic [NUM_LANES-1:0][ENTRY_W-1:0] lane_entry;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    commit_trace_lane #(.LANE_W(LANE_W), .LANE_IDX(i)) u_lane (
      .lane_bus (commit[(NUM_LANES-1-i)*71 +: 71]),
      .vld      (lane_vld[i]),
      .entry    (lane_entry[i])
    );
  end

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [OUT_W-1:0] mem [DEPTH];
  logic             empty, full, pop, accept, drop;
  logic [AW:0]      k, free;
  logic [AW:0]      off [NUM_LANES];

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level       = wr_ptr - rd_ptr;
  assign free        = (AW+1)'(DEPTH) - level;
  assign trace_valid = !empty;
  assign trace_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign pop         = trace_valid && trace_ready;

  // Each valid lane's slot offset is the count of older valid lanes, which
  // packs the group densely in program order.
  always_comb begin
    k = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      off[i] = k;
      if (lane_vld[i]) k = k + {{AW{1'b0}}, 1'b1};
    end
  end

  // Space is judged on start-of-cycle occupancy; a same-cycle pop does not help.
  assign accept = (k != '0) && !full && (k <= free);
  assign drop   = (k != '0) && !accept;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts + TS_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (accept && lane_vld[i])
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        mem[wr_ptr[AW-1:0] + off[i][AW-1:0]] <= {lane_entry[i], ts};
`else
        mem[wr_ptr[AW-1:0] + off[i][AW-1:0]] <= lane_entry[i];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + k;
      if (pop)    rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (~&drop_count) drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

endmodule
